// File: rtl/data_sram_responder_pkg.sv
// Shared constants and the access-class encoding for the data SRAM responder.
package data_sram_responder_pkg;

  localparam int          DATA_SRAM_AW        = 12;
  localparam logic [31:0] DATA_SRAM_BASE      = 32'h0000_0000;
  localparam logic [31:0] DATA_SRAM_OOR_RDATA = 32'h0000_0000;
  localparam int          LANE_W              = 8;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_WRITE,
    ACC_OOR
  } acc_e;

  // An out-of-window access is one class regardless of direction.
  function automatic acc_e classify(input logic en, input logic [3:0] wen,
                                    input logic in_win);
    if (!en)          return ACC_IDLE;
    else if (!in_win) return ACC_OOR;
    else if (|wen)    return ACC_WRITE;
    else              return ACC_READ;
  endfunction

endpackage

// File: rtl/data_sram_responder_byte_merge.sv
// Byte-lane merge shared by the array write port and the write-first read path.
module sram_byte_merge
  import data_sram_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  wen,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-write word memory with registered read data,
// address window check with sticky first-error capture, saturating counters.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          AW        = DATA_SRAM_AW,
  parameter logic [31:0] BASE_ADDR = DATA_SRAM_BASE,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] OOR_RDATA = DATA_SRAM_OOR_RDATA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic             err_flag,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;
  logic          in_win;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   rdata_p1;
  acc_e          acc;
  logic [1:0]    addr_lo_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign idx            = data_sram_addr[AW+1:2];
  assign addr_lo_unused = data_sram_addr[1:0];
  assign in_win         = (data_sram_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign acc            = classify(data_sram_en, data_sram_wen, in_win);
  assign old_word       = mem[idx];

  // With wen=0 the merge returns the old word, so reads share this path.
  sram_byte_merge u_merge (
    .old_word (old_word),
    .new_word (data_sram_wdata),
    .wen      (data_sram_wen),
    .merged   (merged)
  );

  // Array write is independent of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (acc == ACC_WRITE) mem[idx] <= merged;
  end

  // ---- stage p1: registered response and debug state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      unique case (acc)
        ACC_READ: begin
          rdata_p1 <= merged;
          rd_cnt   <= sat_inc(rd_cnt);
        end
        ACC_WRITE: begin
          rdata_p1 <= merged;
          wr_cnt   <= sat_inc(wr_cnt);
        end
        ACC_OOR: begin
          rdata_p1 <= OOR_RDATA;
          err_flag <= 1'b1;
          if (!err_flag) err_addr <= data_sram_addr;
        end
        default: ;
      endcase
    end
  end

  assign data_sram_rdata = rdata_p1;

endmodule
